// File: rtl/chan_gen.sv
// chan_gen -- multi-channel register engine.
//
// Holds NCH independent WIDTH-bit channel registers and updates one of them
// per accepted command on a valid/ready port. Single-cycle ops (NOP, LOAD,
// CLEAR, TOGGLE, INC, DEC) complete the cycle after accept. RAMP walks the
// addressed channel one step per clock toward cmd_data, holding cmd_rdy low
// until the target is reached.
//
// Ports:
//   chan_gen_clk    clock, rising edge
//   chan_gen_rst_n  asynchronous active-low reset
//   cmd_vld/cmd_rdy command handshake (cmd_rdy registered)
//   cmd_ch          target channel index
//   cmd_op          opcode (0 NOP,1 LOAD,2 CLEAR,3 TOGGLE,4 INC,5 DEC,6 RAMP,7 rsvd)
//   cmd_data        load value / ramp target
//   ch_bus          channel i on [i*WIDTH +: WIDTH]
//   done            one-cycle completion pulse
//   err             one-cycle error pulse (bad channel or opcode 7)
//   ch_par          per-channel XOR parity, present only when the macro
//                   CHAN_GEN_PARITY_EN is defined
module chan_gen #(
  parameter int              NCH     = 4,
  parameter int              WIDTH   = 16,
  parameter int              CH_W    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 chan_gen_clk,
  input  logic                 chan_gen_rst_n,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic [NCH*WIDTH-1:0] ch_bus,
  output logic                 done,
  output logic                 err
`ifdef CHAN_GEN_PARITY_EN
  ,
  output logic [NCH-1:0]       ch_par
`endif
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_INC    = 3'd4;
  localparam logic [2:0] OP_DEC    = 3'd5;
  localparam logic [2:0] OP_RAMP   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  // One extra bit so NCH == 2**CH_W compares correctly.
  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RAMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] ch_q [NCH];
  logic [CH_W-1:0]  ramp_ch;
  logic [WIDTH-1:0] ramp_tgt;
  logic [WIDTH-1:0] cmd_cur;
  logic [WIDTH-1:0] ramp_cur;
  logic [WIDTH-1:0] ramp_nxt;
  logic             cmd_bad;
  logic             accept;

  // Result of a single-cycle op; RAMP/NOP leave the value as is.
  function automatic logic [WIDTH-1:0] op_apply(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] data);
    case (op)
      OP_LOAD:   op_apply = data;
      OP_CLEAR:  op_apply = '0;
      OP_TOGGLE: op_apply = ~cur;
      OP_INC:    op_apply = cur + 1'b1;
      OP_DEC:    op_apply = cur - 1'b1;
      default:   op_apply = cur;
    endcase
  endfunction

  // One ramp step toward the target (unsigned compare).
  function automatic logic [WIDTH-1:0] ramp_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    if (cur < tgt) ramp_step = cur + 1'b1;
    else           ramp_step = cur - 1'b1;
  endfunction

  always_comb begin
    cmd_cur  = '0;
    ramp_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CH_W'(i) == cmd_ch)  cmd_cur  = ch_q[i];
      if (CH_W'(i) == ramp_ch) ramp_cur = ch_q[i];
    end
  end

  assign ramp_nxt = ramp_step(ramp_cur, ramp_tgt);
  assign cmd_bad  = ({1'b0, cmd_ch} >= NCH_L) || (cmd_op == OP_RSVD);
  assign accept   = cmd_vld && cmd_rdy;

  always_ff @(posedge chan_gen_clk or negedge chan_gen_rst_n) begin
    if (!chan_gen_rst_n) begin
      state    <= S_INIT;
      cmd_rdy  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ramp_ch  <= '0;
      ramp_tgt <= '0;
      for (int i = 0; i < NCH; i++) ch_q[i] <= RST_VAL;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_INIT: begin
          state   <= S_IDLE;
          cmd_rdy <= 1'b1;
        end
        S_IDLE: begin
          if (accept) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else if (cmd_op == OP_RAMP && cmd_cur != cmd_data) begin
              // Accept edge only latches the job; stepping starts next edge.
              ramp_ch  <= cmd_ch;
              ramp_tgt <= cmd_data;
              state    <= S_RAMP;
              cmd_rdy  <= 1'b0;
            end else begin
              done <= 1'b1;
              for (int i = 0; i < NCH; i++)
                if (CH_W'(i) == cmd_ch) ch_q[i] <= op_apply(cmd_op, cmd_cur, cmd_data);
            end
          end
        end
        S_RAMP: begin
          for (int i = 0; i < NCH; i++)
            if (CH_W'(i) == ramp_ch) ch_q[i] <= ramp_nxt;
          if (ramp_nxt == ramp_tgt) begin
            state   <= S_IDLE;
            cmd_rdy <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= S_INIT;
          cmd_rdy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_bus
    assign ch_bus[g*WIDTH +: WIDTH] = ch_q[g];
  end

`ifdef CHAN_GEN_PARITY_EN
  // Derived from the registered channel values, so it tracks ch_bus exactly
  // and comes out of reset as ^RST_VAL.
  for (genvar g = 0; g < NCH; g++) begin : g_par
    assign ch_par[g] = ^ch_q[g];
  end
`else
  // Parity output not built.
`endif

endmodule

// File: tb/tb_chan_gen.sv
module tb_chan_gen;

  localparam int NCH   = 3;
  localparam int WIDTH = 16;
  localparam int CH_W  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic [CH_W-1:0]      cmd_ch;
  logic [2:0]           cmd_op;
  logic [WIDTH-1:0]     cmd_data;
  logic [NCH*WIDTH-1:0] ch_bus;
  logic                 done;
  logic                 err;
`ifdef CHAN_GEN_PARITY_EN
  logic [NCH-1:0]       ch_par;
`endif

  int npass = 0;
  int ntot  = 0;

  chan_gen #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W), .RST_VAL(16'h0000)) dut (
    .chan_gen_clk   (clk),
    .chan_gen_rst_n (rst_n),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_ch         (cmd_ch),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .ch_bus         (ch_bus),
    .done           (done),
    .err            (err)
`ifdef CHAN_GEN_PARITY_EN
    ,
    .ch_par         (ch_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] ch, input logic [2:0] op,
                       input logic [15:0] data);
    cmd_vld  = vld;
    cmd_ch   = ch;
    cmd_op   = op;
    cmd_data = data;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus", 48'(ch_bus), 48'h0);
    chk("rst_rdy", 48'(cmd_rdy), 48'h0);
    cyc();
    cyc();
    chk("rst_hold_rdy", 48'(cmd_rdy), 48'h0);
    chk("rst_done_err", 48'({done, err}), 48'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy_low", 48'(cmd_rdy), 48'h0);
    cyc();
    chk("rel_rdy_high", 48'(cmd_rdy), 48'h1);
    chk("rel_done_err", 48'({done, err}), 48'h0);

    // LOAD ch2 then back-to-back TOGGLE ch2
    drive(1'b1, 2'd2, 3'd1, 16'h1234);
    cyc();
    chk("load_ch2", 48'(ch_bus[47:32]), 48'h1234);
    chk("load_done", 48'({done, err}), 48'h2);
    drive(1'b1, 2'd2, 3'd3, 16'h0000);
    cyc();
    chk("toggle_ch2", 48'(ch_bus[47:32]), 48'hEDCB);
    chk("toggle_done", 48'(done), 48'h1);

    // Wrap on ch0
    drive(1'b1, 2'd0, 3'd1, 16'hFFFF);
    cyc();
    chk("load_ch0", 48'(ch_bus[15:0]), 48'hFFFF);
    drive(1'b1, 2'd0, 3'd4, 16'h0000);
    cyc();
    chk("inc_wrap", 48'(ch_bus[15:0]), 48'h0000);
    chk("inc_done", 48'(done), 48'h1);
    drive(1'b1, 2'd0, 3'd5, 16'h0000);
    cyc();
    chk("dec_wrap_bus", 48'(ch_bus), 48'hEDCB_0000_FFFF);
    chk("dec_done", 48'(done), 48'h1);
    drive(1'b0, 2'd0, 3'd0, 16'h0000);
    cyc();
    chk("done_one_pulse", 48'(done), 48'h0);

    // CLEAR ch2
    drive(1'b1, 2'd2, 3'd2, 16'h0000);
    cyc();
    chk("clear_bus", 48'(ch_bus), 48'h0000_0000_FFFF);

    // RAMP ch1 3 -> 0, with a held LOAD during the ramp that must be ignored
    drive(1'b1, 2'd1, 3'd1, 16'h0003);
    cyc();
    chk("ramp_pre", 48'(ch_bus[31:16]), 48'h0003);
    drive(1'b1, 2'd1, 3'd6, 16'h0000);
    cyc();
    chk("ramp_acc_val", 48'(ch_bus[31:16]), 48'h0003);
    chk("ramp_acc_rdy_done", 48'({cmd_rdy, done}), 48'h0);
    drive(1'b1, 2'd0, 3'd1, 16'h5555);
    cyc();
    chk("ramp_s1", 48'({cmd_rdy, done, ch_bus[31:16]}), 48'h0_0002);
    cyc();
    chk("ramp_s2", 48'({cmd_rdy, done, ch_bus[31:16]}), 48'h0_0001);
    cyc();
    chk("ramp_s3", 48'({cmd_rdy, done, ch_bus[31:16]}), 48'h3_0000);
    chk("ramp_ignored_vld", 48'(ch_bus[15:0]), 48'hFFFF);
    drive(1'b0, 2'd0, 3'd0, 16'h0000);
    cyc();
    chk("ramp_after", 48'({done, ch_bus[15:0]}), 48'h0_FFFF);

    // RAMP to the current value completes in one cycle
    drive(1'b1, 2'd1, 3'd6, 16'h0000);
    cyc();
    chk("ramp_eq", 48'({cmd_rdy, done, err}), 48'h6);

    // Errors
    drive(1'b1, 2'd3, 3'd1, 16'hAAAA);
    cyc();
    chk("err_ch", 48'({done, err}), 48'h1);
    chk("err_ch_bus", 48'(ch_bus), 48'h0000_0000_FFFF);
    drive(1'b1, 2'd0, 3'd7, 16'h1111);
    cyc();
    chk("err_op7", 48'({done, err}), 48'h1);
    chk("err_op7_bus", 48'(ch_bus), 48'h0000_0000_FFFF);
    drive(1'b0, 2'd0, 3'd0, 16'h0000);
    cyc();
    chk("err_one_pulse", 48'(err), 48'h0);

    drive(1'b1, 2'd1, 3'd1, 16'h0007);
    cyc();
    chk("load7", 48'(ch_bus), 48'h0000_0007_FFFF);
`ifdef CHAN_GEN_PARITY_EN
    chk("parity", 48'(ch_par), 48'h2);
`endif

    // Reset in the middle of a ramp
    drive(1'b1, 2'd0, 3'd1, 16'h0000);
    cyc();
    drive(1'b1, 2'd0, 3'd6, 16'h0100);
    cyc();
    drive(1'b0, 2'd0, 3'd0, 16'h0000);
    for (int i = 0; i < 10; i++) cyc();
    chk("mid_ramp_val", 48'({cmd_rdy, ch_bus[15:0]}), 48'h0_000A);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", 48'(ch_bus), 48'h0);
    chk("mid_rst_ctl", 48'({cmd_rdy, done, err}), 48'h0);
    cyc();
    cyc();
    chk("mid_rst_nodone", 48'({cmd_rdy, done}), 48'h0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy_low", 48'(cmd_rdy), 48'h0);
    cyc();
    chk("mid_rel_rdy", 48'({cmd_rdy, done, err}), 48'h4);
    cyc();
    chk("mid_rel_bus", 48'({done, ch_bus}), 48'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
